btn_sequence_recorder: RTL and testbench

BTN_SEQUENCE_RECORDER -- requirements
Module: btn_sequence_recorder

---
 rtl/btn_sequence_recorder.sv | 108 ++++++++++
 tb/tb_btn_sequence_recorder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/btn_sequence_recorder.sv
// btn_sequence_recorder: debounces three player buttons and records accepted presses into a 16-entry store.
// Ports: clk_i/rst_i clock and sync active-high reset; btn_i raw buttons; record_en_i enables store writes;
// clear_i empties the store; rd_addr_i/rd_data_o registered read port; wr_count_o/full_o store fill level;
// press_valid_o/press_number_o accepted press; invalid_press_o multi-button press; overflow_o press lost to a full store.
module btn_sequence_recorder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] btn_i,
  input  logic       record_en_i,
  input  logic       clear_i,
  input  logic [3:0] rd_addr_i,
  output logic [1:0] rd_data_o,
  output logic [4:0] wr_count_o,
  output logic       full_o,
  output logic       press_valid_o,
  output logic [1:0] press_number_o,
  output logic       invalid_press_o,
  output logic       overflow_o
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] cand_q, cand_d;
  logic [2:0] sync1_q, btn_s_q;
  logic       fire, one_hot, wr_en;
  logic [1:0] num;
  logic       press_valid_q, press_valid_d;
  logic       invalid_q, invalid_d;
  logic       overflow_q, overflow_d;
  logic [1:0] press_number_q;
  logic [4:0] wr_count_q, wr_count_d;
  logic [1:0] rd_data_q;
  logic [1:0] mem_q [16];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: if (btn_s_q != '0) begin
        cand_d  = btn_s_q;
        cnt_d   = '0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: if (btn_s_q != cand_q) state_d = IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          fire    = 1'b1;
        end else cnt_d = cnt_q + 8'd1;
      HELD: if (btn_s_q == '0) begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: if (btn_s_q != '0) state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  assign one_hot       = cand_q == 3'b001 || cand_q == 3'b010 || cand_q == 3'b100;
  assign num           = cand_q[2] ? 2'd2 : cand_q[1] ? 2'd1 : 2'd0;
  assign full_o        = wr_count_q == 5'd16;
  assign press_valid_d = fire && one_hot;
  assign invalid_d     = fire && !one_hot;
  // clear takes priority over both the write and the overflow report
  assign wr_en         = press_valid_d && record_en_i && !full_o && !clear_i;
  assign overflow_d    = press_valid_d && record_en_i && full_o && !clear_i;
  assign wr_count_d    = clear_i ? 5'd0 : wr_en ? wr_count_q + 5'd1 : wr_count_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q        <= '0;
      btn_s_q        <= '0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      cand_q         <= '0;
      press_valid_q  <= 1'b0;
      invalid_q      <= 1'b0;
      overflow_q     <= 1'b0;
      press_number_q <= '0;
      wr_count_q     <= '0;
      rd_data_q      <= '0;
      mem_q          <= '{default: '0};
    end else begin
      sync1_q        <= btn_i;
      btn_s_q        <= sync1_q;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cand_q         <= cand_d;
      press_valid_q  <= press_valid_d;
      invalid_q      <= invalid_d;
      overflow_q     <= overflow_d;
      if (press_valid_d) press_number_q <= num;
      if (wr_en) mem_q[wr_count_q[3:0]] <= num;
      // read-before-write: a same-edge write shows up one cycle later
      rd_data_q      <= mem_q[rd_addr_i];
      wr_count_q     <= wr_count_d;
    end
  end
  assign rd_data_o       = rd_data_q;
  assign wr_count_o      = wr_count_q;
  assign press_valid_o   = press_valid_q;
  assign press_number_o  = press_number_q;
  assign invalid_press_o = invalid_q;
  assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_btn_sequence_recorder.sv
// tb_btn_sequence_recorder: directed self-checking bench for btn_sequence_recorder.
module tb_btn_sequence_recorder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = '0;
  logic       record_en = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [1:0] rd_data;
  logic [4:0] wr_count;
  logic       full, press_valid, invalid_press, overflow;
  logic [1:0] press_number;
  int total = 0, passed = 0, failed = 0;
  int pv_cnt = 0, inv_cnt = 0, ov_cnt = 0;
  int pv0, inv0, ov0;

  btn_sequence_recorder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn), .record_en_i(record_en), .clear_i(clear),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .wr_count_o(wr_count), .full_o(full),
    .press_valid_o(press_valid), .press_number_o(press_number),
    .invalid_press_o(invalid_press), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_valid) pv_cnt++;
    if (invalid_press) inv_cnt++;
    if (overflow) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [2:0] b, input int hold);
    btn = b;
    tick(hold);
    btn = '0;
    tick(10);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_press_valid", 32'(press_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_invalid", 32'(invalid_press), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // single press of button 1: event exactly after edge 7
    pv0 = pv_cnt;
    btn = 3'b010;
    tick(6);
    chk("lat_early", 32'(press_valid), 0);
    tick(1);
    chk("lat_valid", 32'(press_valid), 1);
    chk("lat_number", 32'(press_number), 1);
    chk("lat_wr_count", 32'(wr_count), 1);
    tick(1);
    chk("pulse_width", 32'(press_valid), 0);
    tick(12);
    btn = '0;
    tick(10);
    chk("one_event", 32'(pv_cnt - pv0), 1);
    rd_addr = 4'd0;
    tick(1);
    chk("mem0", 32'(rd_data), 1);

    // glitch shorter than debounce window
    pv0 = pv_cnt;
    press(3'b001, 3);
    chk("glitch_no_event", 32'(pv_cnt - pv0), 0);
    chk("glitch_wr_count", 32'(wr_count), 1);

    // multi-button press
    pv0 = pv_cnt;
    inv0 = inv_cnt;
    press(3'b101, 10);
    chk("multi_invalid", 32'(inv_cnt - inv0), 1);
    chk("multi_no_valid", 32'(pv_cnt - pv0), 0);
    chk("multi_wr_count", 32'(wr_count), 1);

    // clear coincident with third press
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_wr_count", 32'(wr_count), 0);
    for (int i = 0; i < 3; i++) press(3'b100, 10);
    chk("prefill_count", 32'(wr_count), 3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    press(3'b001, 10);
    press(3'b001, 10);
    chk("two_presses", 32'(wr_count), 2);
    ov0 = ov_cnt;
    btn = 3'b001;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_press_valid", 32'(press_valid), 1);
    chk("clr_wr_count", 32'(wr_count), 0);
    chk("clr_overflow", 32'(overflow), 0);
    tick(13);
    btn = '0;
    tick(10);
    chk("clr_no_overflow", 32'(ov_cnt - ov0), 0);
    rd_addr = 4'd2;
    tick(1);
    chk("clr_mem2_kept", 32'(rd_data), 2);

    // fill to 16 and overflow on 17th
    for (int i = 0; i < 16; i++) press(3'b100, 10);
    chk("fill_count", 32'(wr_count), 16);
    chk("fill_full", 32'(full), 1);
    ov0 = ov_cnt;
    btn = 3'b100;
    tick(7);
    chk("ovf_valid", 32'(press_valid), 1);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count_hold", 32'(wr_count), 16);
    tick(1);
    chk("ovf_pulse_end", 32'(overflow), 0);
    tick(5);
    btn = '0;
    tick(10);
    chk("ovf_once", 32'(ov_cnt - ov0), 1);
    rd_addr = 4'd15;
    tick(1);
    chk("mem15", 32'(rd_data), 2);

    // reset during DEBOUNCE with button held
    pv0 = pv_cnt;
    btn = 3'b010;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_wr_count", 32'(wr_count), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_no_event", 32'(pv_cnt - pv0), 0);
    tick(6);
    chk("rerun_early", 32'(press_valid), 0);
    tick(1);
    chk("rerun_valid", 32'(press_valid), 1);
    chk("rerun_wr_count", 32'(wr_count), 1);
    btn = '0;
    tick(12);
    chk("rerun_once", 32'(pv_cnt - pv0), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
